// File: rtl/golden_nonce_tx.sv
// golden_nonce_tx: buffers golden nonces from the hashcore in a small FIFO
// and sends each one as four 8N1 UART bytes, least-significant byte first.
// A strobe that arrives while the FIFO is full is dropped and latches the
// sticky overflow flag.

module golden_nonce_tx #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        hash_clk,
    input  logic        reset,
    input  logic [31:0] golden_nonce_in,
    input  logic        golden_nonce_match,
    output logic        txd,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = 16;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    // Transmitter state
    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       shift_q, shift_d;
    logic              txd_q, txd_d;

    logic push_s;
    logic pop_s;
    logic full_s;
    logic empty_s;
    logic baud_done_s;

    // FIFO control: the transmitter pops only from IDLE, and a pop frees a slot
    // for a push arriving in the same cycle even when the FIFO is full.
    always_comb begin
        full_s     = (count_q == CNT_FULL);
        empty_s    = (count_q == CNT_ZERO);
        pop_s      = (state_q == ST_IDLE) && !empty_s;
        push_s     = golden_nonce_match && (!full_s || pop_s);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (golden_nonce_match & !push_s);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // UART framing: txd_d is the line level for the state being entered, so the
    // registered txd changes on the same edge as the state.
    always_comb begin
        baud_done_s = (baud_q == BAUD_LAST);
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
        txd_d       = txd_q;

        case (state_q)
            ST_IDLE: begin
                baud_d = {BAUD_W{1'b0}};
                if (pop_s) begin
                    shift_d = fifo_mem_q[rd_ptr_q];
                    byte_d  = 2'd0;
                    bit_d   = 3'd0;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                end
            end

            ST_START: begin
                if (baud_done_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                    txd_d   = 1'b0;
                end
            end

            ST_DATA: begin
                if (baud_done_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    // Shifting every bit leaves the next byte in [7:0] after bit 7.
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                    txd_d  = shift_q[0];
                end
            end

            ST_STOP: begin
                if (baud_done_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = ST_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                    txd_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = {BAUD_W{1'b0}};
                bit_d   = 3'd0;
                byte_d  = 2'd0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= CNT_ZERO;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            baud_q     <= {BAUD_W{1'b0}};
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            shift_q    <= 32'd0;
            txd_q      <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
        end
    end

    // FIFO storage write; contents need no reset because count gates every read.
    always_ff @(posedge hash_clk) begin
        if (push_s && !reset) begin
            fifo_mem_q[wr_ptr_q] <= golden_nonce_in;
        end
    end

    assign txd       = txd_q;
    assign busy      = (state_q != ST_IDLE) | !empty_s;
    assign fifo_full = full_s;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Testbench for golden_nonce_tx: a scoreboard of expected nonces is filled
// as strobes are driven and drained by a cycle-accurate UART frame decoder.

module tb_golden_nonce_tx;

    localparam int BAUD_DIV   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_CYC  = 40 * BAUD_DIV;
    localparam int NEXT_FRAME = FRAME_CYC + 1;

    logic        hash_clk = 1'b0;
    logic        reset;
    logic [31:0] golden_nonce_in;
    logic        golden_nonce_match;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [$];
    int          start_q [$];
    int          fall_q [$];

    logic        mon_flush  = 1'b1;
    logic        mon_active = 1'b0;
    int          mon_off    = 0;
    int          mon_start  = 0;
    logic [31:0] mon_word   = 32'd0;

    golden_nonce_tx #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .hash_clk           (hash_clk),
        .reset              (reset),
        .golden_nonce_in    (golden_nonce_in),
        .golden_nonce_match (golden_nonce_match),
        .txd                (txd),
        .busy               (busy),
        .fifo_full          (fifo_full),
        .overflow           (overflow)
    );

    // Free-running clock.
    always #5 hash_clk = ~hash_clk;

    // Edge counter used to timestamp events.
    always @(posedge hash_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
        end
    endtask

    // Frame decoder: samples each bit in the middle of its period.
    initial begin
        forever begin
            @(negedge hash_clk);
            if (mon_flush) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (txd === 1'b0) begin
                    mon_active = 1'b1;
                    mon_off    = 0;
                    mon_word   = 32'd0;
                    mon_start  = cyc;
                end
            end else begin
                mon_off++;
            end
            if (mon_active && !mon_flush) begin
                int byte_i;
                int w;
                int bitpos;
                byte_i = mon_off / 40 / (BAUD_DIV / 4);
                byte_i = mon_off / (10 * BAUD_DIV);
                w      = mon_off % (10 * BAUD_DIV);
                bitpos = w / BAUD_DIV;
                if ((w % BAUD_DIV) == (BAUD_DIV / 2)) begin
                    if (bitpos == 0) begin
                        check("start_bit", 32'(txd), 32'd0);
                    end else if (bitpos == 9) begin
                        check("stop_bit", 32'(txd), 32'd1);
                    end else begin
                        mon_word[byte_i * 8 + bitpos - 1] = txd;
                    end
                end
                if (mon_off == FRAME_CYC - 1) begin
                    check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check("frame_data", mon_word, exp_q.pop_front());
                    end
                    start_q.push_back(mon_start);
                    mon_active = 1'b0;
                end
            end
        end
    end

    // Records the cycle on which busy falls.
    initial begin
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge hash_clk);
            if (busy_prev === 1'b1 && busy === 1'b0) begin
                fall_q.push_back(cyc);
            end
            busy_prev = busy;
        end
    end

    // Hard stop in case something hangs.
    initial begin
        repeat (30000) @(posedge hash_clk);
        $display("FAIL watchdog: got cycle %0d, want finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int pop_start();
        if (start_q.size() == 0) return -1;
        return start_q.pop_front();
    endfunction

    function automatic int pop_fall();
        if (fall_q.size() == 0) return -1;
        return fall_q.pop_front();
    endfunction

    task automatic clear_obs();
        exp_q.delete();
        start_q.delete();
        fall_q.delete();
    endtask

    task automatic sync();
        @(posedge hash_clk);
        #1;
    endtask

    // Drives one strobe; it is sampled on the next edge. Returns just after that edge.
    task automatic drive(input logic [31:0] v, input bit expect_out);
        golden_nonce_match = 1'b1;
        golden_nonce_in    = v;
        if (expect_out) exp_q.push_back(v);
        sync();
        golden_nonce_match = 1'b0;
    endtask

    task automatic wait_until(input int edge_no);
        while (cyc < edge_no) sync();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0 || mon_active) && n < budget) begin
            @(negedge hash_clk);
            n++;
        end
        check(tag, 32'(exp_q.size() == 0 && busy === 1'b0 && !mon_active), 32'd1);
    endtask

    task automatic do_reset();
        mon_flush = 1'b1;
        reset     = 1'b1;
        sync();
        sync();
        reset = 1'b0;
        clear_obs();
        mon_flush = 1'b0;
    endtask

    initial begin
        int  k;
        int  s;
        int  s2;
        int  lows;
        bit  full_seen;

        reset              = 1'b1;
        golden_nonce_match = 1'b0;
        golden_nonce_in    = 32'd0;
        mon_flush          = 1'b1;

        // Reset, with a strobe coinciding with the last reset edge.
        sync();
        sync();
        golden_nonce_match = 1'b1;
        golden_nonce_in    = 32'hDEADBEEF;
        sync();
        golden_nonce_match = 1'b0;
        reset              = 1'b0;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        repeat (4) sync();
        check("rst_no_push_busy", 32'(busy), 32'd0);
        check("rst_no_push_txd", 32'(txd), 32'd1);
        clear_obs();
        mon_flush = 1'b0;

        // Single nonce: latency, byte order, frame length, busy release.
        k = cyc + 1;
        drive(32'h12345678, 1'b1);
        check("t1_txd_before_pop", 32'(txd), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_drain("t1_drain", 400);
        s = pop_start();
        check("t1_start", 32'(s), 32'(k + 1));
        check("t1_busy_fall", 32'(pop_fall()), 32'(s + FRAME_CYC));

        // Six consecutive strobes: five sent, the sixth dropped.
        clear_obs();
        sync();
        k = cyc + 1;
        full_seen = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(32'(i), i <= 5);
            if (fifo_full === 1'b1) full_seen = 1'b1;
        end
        check("t2_full_seen", 32'(full_seen), 32'd1);
        check("t2_ovf", 32'(overflow), 32'd1);
        wait_drain("t2_drain", 1000);
        for (int i = 0; i < 5; i++) begin
            check("t2_start", 32'(pop_start()), 32'(k + 1 + NEXT_FRAME * i));
        end
        check("t2_ovf_sticky", 32'(overflow), 32'd1);
        check("t2_full_end", 32'(fifo_full), 32'd0);

        // Full FIFO, strobe coincident with the IDLE pop: accepted, no overflow.
        do_reset();
        check("t3_ovf_cleared", 32'(overflow), 32'd0);
        sync();
        k = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            drive(32'hA0000000 | 32'(i), 1'b1);
        end
        s = k + 1;
        wait_until(s + FRAME_CYC);
        check("t3_full_before", 32'(fifo_full), 32'd1);
        drive(32'hA00000FF, 1'b1);
        check("t3_full_after", 32'(fifo_full), 32'd1);
        check("t3_ovf_after", 32'(overflow), 32'd0);
        wait_drain("t3_drain", 1200);
        check("t3_start0", 32'(pop_start()), 32'(s));
        check("t3_start1", 32'(pop_start()), 32'(s + NEXT_FRAME));
        check("t3_ovf_end", 32'(overflow), 32'd0);

        // Two strobes one cycle apart: one idle-high cycle between frames.
        clear_obs();
        sync();
        k = cyc + 1;
        drive(32'h0F1E2D3C, 1'b1);
        sync();
        drive(32'h80000001, 1'b1);
        wait_drain("t4_drain", 500);
        s  = pop_start();
        s2 = pop_start();
        check("t4_start", 32'(s), 32'(k + 1));
        check("t4_gap", 32'(s2 - s), 32'(NEXT_FRAME));
        check("t4_busy_fall", 32'(pop_fall()), 32'(s2 + FRAME_CYC));

        // Reset during DATA of byte 2, then a keepalive nonce.
        clear_obs();
        sync();
        k = cyc + 1;
        drive(32'hCAFEF00D, 1'b0);
        s = k + 1;
        wait_until(s + 89);
        mon_flush = 1'b1;
        reset     = 1'b1;
        sync();
        reset = 1'b0;
        check("t5_txd", 32'(txd), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge hash_clk);
            if (txd !== 1'b1) lows++;
        end
        check("t5_quiet", 32'(lows), 32'd0);
        clear_obs();
        mon_flush = 1'b0;
        sync();
        k = cyc + 1;
        drive(32'hFFFFFFFF, 1'b1);
        wait_drain("t5_drain", 400);
        check("t5_start", 32'(pop_start()), 32'(k + 1));
        check("t5_ovf_end", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
